// File: rtl/gf180mcu_rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with bounded hold time and optional bus turnaround gap.
// Grants are registered one-hot. Reset release is synchronised before the first arbitration.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no owner; arbitrate among live requests starting at ptr
// GRANT | one requester owns the resource; hold counter running
// GAP   | one all-zero turnaround cycle after a grant ends
module gf180mcu_rr_arb4_ctrl #(
   parameter int unsigned MAX_HOLD = 16,
   parameter bit          GAP_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       rn,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gid,
   output logic       busy,
   output logic       pre,
   output logic       noreq,
   inout  wire        vdd,
   inout  wire        vss
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam bit         HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] gid_q, gid_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] sync_q;
   logic       arb_en;
   logic [1:0] pick_idx;
   logic       owner_req;
   logic       other_req;
   logic       release_c;
   logic       preempt_c;

   wire unused_rails;
   assign unused_rails = vdd ^ vss;

   // first requester at or after p, wrapping
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] res;
      logic [1:0] idx;
      res = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) res = idx;
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign arb_en = sync_q[1];
   assign noreq  = ~(req[0] | req[1] | req[2] | req[3]);

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         state_q <= ST_IDLE;
         gnt_q   <= 4'b0000;
         gid_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pick_idx  = rr_pick(req, ptr_q);
   assign owner_req = req[gid_q];
   assign other_req = |(req & ~gnt_q);
   assign release_c = (state_q == ST_GRANT) && !owner_req;
   // release wins over preemption, so the owner's request must still be up
   assign preempt_c = (state_q == ST_GRANT) && owner_req && HOLD_EN && other_req &&
                      (cnt_q >= HOLD_LAST);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            gnt_d = 4'b0000;
            if (arb_en && !noreq) begin
               state_d = ST_GRANT;
               gnt_d   = 4'b0001 << pick_idx;
               gid_d   = pick_idx;
               cnt_d   = 8'd0;
            end
         end
         ST_GRANT: begin
            if (release_c || preempt_c) begin
               gnt_d   = 4'b0000;
               ptr_d   = gid_q + 2'd1;
               state_d = GAP_EN ? ST_GAP : ST_IDLE;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_GAP: begin
            gnt_d   = 4'b0000;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = 4'b0000;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign gnt  = gnt_q;
   assign gid  = gid_q;
   assign busy = (state_q == ST_GRANT);
   assign pre  = preempt_c;

endmodule

// File: tb/tb_gf180mcu_rr_arb4_ctrl.sv
// Bench for gf180mcu_rr_arb4_ctrl: two instances (hold 4 with gap, hold 16 without gap)
// share stimulus; a cycle model feeds a scoreboard, plus directed checks of key scenarios.
`timescale 1ns/1ps

module tb_gf180mcu_rr_arb4_ctrl;

   logic       clk = 1'b0;
   logic       rn  = 1'b1;
   logic [3:0] req = 4'hF;
   wire        vdd;
   wire        vss;
   assign vdd = 1'b1;
   assign vss = 1'b0;

   logic [3:0] gnt_a, gnt_b;
   logic [1:0] gid_a, gid_b;
   logic       busy_a, busy_b, pre_a, pre_b, noreq_a, noreq_b;

   gf180mcu_rr_arb4_ctrl #(.MAX_HOLD(4), .GAP_EN(1'b1)) dut_a (
      .clk(clk), .rn(rn), .req(req), .gnt(gnt_a), .gid(gid_a), .busy(busy_a),
      .pre(pre_a), .noreq(noreq_a), .vdd(vdd), .vss(vss));

   gf180mcu_rr_arb4_ctrl #(.MAX_HOLD(16), .GAP_EN(1'b0)) dut_b (
      .clk(clk), .rn(rn), .req(req), .gnt(gnt_b), .gid(gid_b), .busy(busy_b),
      .pre(pre_b), .noreq(noreq_b), .vdd(vdd), .vss(vss));

   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int obs, input int want);
      n_run++;
      if (obs != want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   // reference model, index 0 = dut_a, 1 = dut_b
   int         m_state [2];
   int         m_gid   [2];
   int         m_ptr   [2];
   int         m_cnt   [2];
   int         m_sync  [2];
   logic [3:0] m_gnt   [2];
   int         hold    [2] = '{4, 16};
   int         gap     [2] = '{1, 0};

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0;
         m_gid[d]   = 0;
         m_ptr[d]   = 0;
         m_cnt[d]   = 0;
         m_sync[d]  = 0;
         m_gnt[d]   = 4'b0000;
      end
   endfunction

   function automatic void model_step(input int d, input logic [3:0] r);
      int         o;
      logic       en;
      logic [3:0] others;
      en = (m_sync[d] >= 2);
      if (m_sync[d] < 2) m_sync[d] = m_sync[d] + 1;
      o      = m_gid[d];
      others = r & ~(4'b0001 << o);
      case (m_state[d])
         0: begin
            if (en && r != 4'b0000) begin
               for (int k = 0; k < 4; k++) begin
                  o = (m_ptr[d] + k) % 4;
                  if (r[o]) break;
               end
               m_gnt[d]   = 4'b0001 << o;
               m_gid[d]   = o;
               m_cnt[d]   = 0;
               m_state[d] = 1;
            end
         end
         1: begin
            if (!r[o] || (hold[d] != 0 && m_cnt[d] >= hold[d] - 1 && others != 4'b0000)) begin
               m_gnt[d]   = 4'b0000;
               m_ptr[d]   = (o + 1) % 4;
               m_state[d] = (gap[d] != 0) ? 2 : 0;
            end else if (m_cnt[d] < 255) begin
               m_cnt[d] = m_cnt[d] + 1;
            end
         end
         default: m_state[d] = 0;
      endcase
   endfunction

   function automatic logic exp_pre(input int d, input logic [3:0] r);
      logic [3:0] others;
      others = r & ~(4'b0001 << m_gid[d]);
      return (m_state[d] == 1) && r[m_gid[d]] && (hold[d] != 0) &&
             (m_cnt[d] >= hold[d] - 1) && (others != 4'b0000);
   endfunction

   typedef struct packed {
      logic       d;
      logic [3:0] gnt;
      logic [1:0] gid;
      logic       busy;
      logic       pre;
      logic       noreq;
   } exp_t;

   exp_t sb[$];

   task automatic edge_step();
      @(posedge clk);
      if (rn) begin
         model_step(0, req);
         model_step(1, req);
      end
      #1;
   endtask

   task automatic drive(input logic [3:0] r, input logic rn_v);
      exp_t e;
      rn = rn_v;
      if (!rn_v) model_reset();
      req = r;
      for (int d = 0; d < 2; d++) begin
         e.d     = 1'(d);
         e.gnt   = m_gnt[d];
         e.gid   = 2'(m_gid[d]);
         e.busy  = (m_state[d] == 1);
         e.pre   = exp_pre(d, r);
         e.noreq = (r == 4'b0000);
         sb.push_back(e);
      end
      #1;
   endtask

   exp_t       ce;
   logic [3:0] og;
   logic [1:0] oi;
   logic       ob, op, on;

   always @(negedge clk) begin
      while (sb.size() != 0) begin
         ce = sb.pop_front();
         if (ce.d == 1'b0) begin
            og = gnt_a; oi = gid_a; ob = busy_a; op = pre_a; on = noreq_a;
         end else begin
            og = gnt_b; oi = gid_b; ob = busy_b; op = pre_b; on = noreq_b;
         end
         chk($sformatf("sb_d%0d_gnt", ce.d),   int'(og), int'(ce.gnt));
         chk($sformatf("sb_d%0d_gid", ce.d),   int'(oi), int'(ce.gid));
         chk($sformatf("sb_d%0d_busy", ce.d),  int'(ob), int'(ce.busy));
         chk($sformatf("sb_d%0d_pre", ce.d),   int'(op), int'(ce.pre));
         chk($sformatf("sb_d%0d_noreq", ce.d), int'(on), int'(ce.noreq));
      end
   end

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         edge_step();
         drive(4'b0000, 1'b1);
         if (m_state[0] == 0 && m_state[1] == 0) break;
      end
      chk("drain_busy", int'({busy_a, busy_b}), 0);
   endtask

   int         ng, zrun, bad, pre_seen;
   logic [3:0] seen [5];
   logic [3:0] last, g, r;
   logic [3:0] t2_want [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
   logic [3:0] t3_g    [7] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h1};
   logic       t3_p    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      model_reset();
      #1 rn = 1'b0;
      edge_step(); drive(4'hF, 1'b0);
      edge_step(); drive(4'hF, 1'b0);
      chk("rst_gnt",   int'(gnt_a),   0);
      chk("rst_gid",   int'(gid_a),   0);
      chk("rst_busy",  int'(busy_a),  0);
      chk("rst_pre",   int'(pre_a),   0);
      chk("rst_noreq", int'(noreq_a), 0);

      // reset release with all requests up: two quiet edges, then requester 0
      edge_step(); drive(4'hF, 1'b1);
      edge_step(); drive(4'hF, 1'b1);
      chk("t1_edge1_gnt", int'(gnt_a), 0);
      edge_step(); drive(4'hF, 1'b1);
      chk("t1_edge2_gnt", int'(gnt_a), 0);
      edge_step(); drive(4'hF, 1'b1);
      chk("t1_edge3_gnt", int'(gnt_a), 1);
      chk("t1_edge3_gid", int'(gid_a), 0);
      chk("t1_noreq",     int'(noreq_a), 0);

      // rotation: each owner of dut_a drops its request in its 3rd grant cycle
      for (int k = 0; k < 5; k++) seen[k] = 4'h0;
      ng = 1; seen[0] = gnt_a; last = gnt_a; zrun = 0;
      for (int i = 0; i < 60 && ng < 5; i++) begin
         edge_step();
         r = 4'hF;
         if (m_state[0] == 1 && m_cnt[0] == 2) r[m_gid[0]] = 1'b0;
         drive(r, 1'b1);
         g = gnt_a;
         if (g != 4'h0 && last == 4'h0) begin
            seen[ng] = g;
            chk($sformatf("t2_gap%0d", ng), zrun, 2);
            ng++;
         end
         zrun = (g == 4'h0) ? zrun + 1 : 0;
         last = g;
      end
      chk("t2_grants", ng, 5);
      for (int k = 0; k < 5; k++) chk($sformatf("t2_seq%0d", k), int'(seen[k]), int'(t2_want[k]));

      // preemption after MAX_HOLD=4 cycles on dut_a
      drain();
      edge_step(); drive(4'b0100, 1'b1);
      for (int k = 0; k < 7; k++) begin
         edge_step(); drive(4'b0101, 1'b1);
         chk($sformatf("t3_gnt%0d", k), int'(gnt_a), int'(t3_g[k]));
         chk($sformatf("t3_pre%0d", k), int'(pre_a), int'(t3_p[k]));
      end

      // lone owner holds indefinitely; a late competitor preempts at once
      drain();
      edge_step(); drive(4'b0010, 1'b1);
      edge_step(); drive(4'b0010, 1'b1);
      bad = 0; pre_seen = 0;
      for (int i = 0; i < 300; i++) begin
         edge_step(); drive(4'b0010, 1'b1);
         if (gnt_b != 4'b0010 || gnt_a != 4'b0010) bad++;
         if (pre_a || pre_b) pre_seen++;
      end
      chk("t4_hold", bad, 0);
      chk("t4_no_pre", pre_seen, 0);
      edge_step(); drive(4'b1010, 1'b1);
      chk("t4_pre_b", int'(pre_b), 1);
      chk("t4_pre_a", int'(pre_a), 1);
      edge_step(); drive(4'b1010, 1'b1);
      chk("t4_rel_b", int'(gnt_b), 0);
      chk("t4_rel_pre", int'(pre_b), 0);
      edge_step(); drive(4'b1010, 1'b1);
      chk("t4_next_b", int'(gnt_b), 8);
      chk("t4_next_gid", int'(gid_b), 3);
      edge_step(); drive(4'b1010, 1'b1);
      chk("t4_next_a", int'(gnt_a), 8);

      // asynchronous reset while requester 3 owns the resource
      @(negedge clk);
      #1 rn = 1'b0;
      model_reset();
      #1;
      chk("t5_async_gnt_a", int'(gnt_a), 0);
      chk("t5_async_gnt_b", int'(gnt_b), 0);
      chk("t5_async_busy",  int'(busy_b), 0);
      edge_step(); drive(4'b1001, 1'b0);
      edge_step(); drive(4'b1001, 1'b1);
      edge_step(); drive(4'b1001, 1'b1);
      edge_step(); drive(4'b1001, 1'b1);
      edge_step(); drive(4'b1001, 1'b1);
      chk("t5_regrant_a", int'(gnt_a), 1);
      chk("t5_regrant_b", int'(gnt_b), 1);

      // no requests, then a single-cycle request on the no-gap instance
      drain();
      chk("t6_noreq", int'(noreq_b), 1);
      chk("t6_idle_gnt", int'(gnt_b), 0);
      edge_step(); drive(4'b0100, 1'b1);
      chk("t6_noreq_lo", int'(noreq_b), 0);
      edge_step(); drive(4'b0000, 1'b1);
      chk("t6_short_gnt", int'(gnt_b), 4);
      edge_step(); drive(4'b0000, 1'b1);
      chk("t6_after_gnt", int'(gnt_b), 0);
      chk("t6_after_busy", int'(busy_b), 0);
      edge_step(); drive(4'b0000, 1'b1);
      chk("t6_idle_again", int'(gnt_b), 0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
